cnn_layer_accel_job_ctrl: RTL

CNN_LAYER_ACCEL_JOB_CTRL -- requirements
Module: cnn_layer_accel_job_ctrl

---
 rtl/cnn_layer_accel_job_pkg.sv | 21 ++
 rtl/cnn_layer_accel_job_ctrl_beat_cntr.sv | 43 ++++
 rtl/cnn_layer_accel_job_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_accel_job_pkg.sv
// Shared types and descriptor layout for the CNN layer job controller.
// Imported by the controller top and its beat counters.
package cnn_layer_accel_job_pkg;

  localparam int CNT_WIDTH_DEF = 16;

  localparam int FIELD_W   = 16;
  localparam int PIX_LSB   = 0;
  localparam int WGT_LSB   = 16;
  localparam int RES_LSB   = 32;
  localparam int FIELD_END = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_REQ,
    ST_FETCH,
    ST_PROCESS,
    ST_COMPLETE
  } job_state_e;

endpackage

// File: rtl/cnn_layer_accel_job_ctrl_beat_cntr.sv
// Saturating beat counter: counts enabled beats up to a target.
// Reports both the current and the next-cycle "reached target" status.
module cnn_layer_accel_beat_cntr
  import cnn_layer_accel_job_pkg::*;
#(
  parameter int C_CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [C_CNT_WIDTH-1:0] target_i,
  output logic [C_CNT_WIDTH-1:0] count_o,
  output logic                   done_o,
  output logic                   done_nxt_o
);

  localparam logic [C_CNT_WIDTH-1:0] ONE = 1;

  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < target_i)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o    = cnt_q;
  assign done_o     = (cnt_q == target_i);
  assign done_nxt_o = (cnt_d == target_i);

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Job sequencer for one CNN layer: accept, fetch, process, complete.
// Every output is a register loaded from the next-state decode.
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_job_pkg::*;
#(
  parameter int C_CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int C_PARAM_WIDTH = 128
) (
  input  logic                     clk_if,
  input  logic                     rst_n,
  input  logic                     job_start,
  output logic                     job_accept,
  input  logic [C_PARAM_WIDTH-1:0] job_parameters,
  output logic                     job_fetch_request,
  input  logic                     job_fetch_ack,
  output logic                     job_fetch_complete,
  output logic                     job_complete,
  input  logic                     job_complete_ack,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
  input  logic                     weight_valid,
  output logic                     weight_ready,
  input  logic                     result_valid,
  input  logic                     result_accept,
  output logic                     core_start,
  output logic                     busy
);

  job_state_e state_q, state_d;

  logic [C_CNT_WIDTH-1:0] pix_tgt_q, wgt_tgt_q, res_tgt_q;
  logic [C_CNT_WIDTH-1:0] pix_cnt, wgt_cnt, res_cnt;
  logic pix_done, wgt_done, res_done;
  logic pix_done_nxt, wgt_done_nxt, res_done_nxt;
  logic pix_en, wgt_en, res_en;
  logic latch_en, cnt_clr;

  logic acc_q, acc_d;
  logic req_q, req_d;
  logic fcmp_q, fcmp_d;
  logic cmp_q, cmp_d;
  logic prdy_q, prdy_d;
  logic wrdy_q, wrdy_d;
  logic cs_q, cs_d;
  logic busy_q, busy_d;

  assign pix_en = pixel_valid & prdy_q;
  assign wgt_en = weight_valid & wrdy_q;
  assign res_en = result_valid & result_accept &
                  (state_q == ST_PROCESS);

  always_comb begin
    state_d  = state_q;
    acc_d    = 1'b0;
    fcmp_d   = 1'b0;
    cs_d     = 1'b0;
    latch_en = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (job_start) begin
          state_d  = ST_FETCH_REQ;
          acc_d    = 1'b1;
          latch_en = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      ST_FETCH_REQ: begin
        if (job_fetch_ack) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (pix_done && wgt_done) begin
          state_d = ST_PROCESS;
          fcmp_d  = 1'b1;
          cs_d    = 1'b1;
        end
      end
      ST_PROCESS: begin
        if (res_done) state_d = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        if (job_complete_ack) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d  = (state_d == ST_FETCH_REQ);
    cmp_d  = (state_d == ST_COMPLETE);
    busy_d = (state_d != ST_IDLE);
    // ready looks one beat ahead so it falls right after the final beat
    prdy_d = (state_d == ST_FETCH) && !pix_done_nxt;
    wrdy_d = (state_d == ST_FETCH) && !wgt_done_nxt;
  end

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pix_tgt_q <= '0;
      wgt_tgt_q <= '0;
      res_tgt_q <= '0;
      acc_q     <= 1'b0;
      req_q     <= 1'b0;
      fcmp_q    <= 1'b0;
      cmp_q     <= 1'b0;
      prdy_q    <= 1'b0;
      wrdy_q    <= 1'b0;
      cs_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        pix_tgt_q <= C_CNT_WIDTH'(job_parameters[PIX_LSB +: FIELD_W]);
        wgt_tgt_q <= C_CNT_WIDTH'(job_parameters[WGT_LSB +: FIELD_W]);
        res_tgt_q <= C_CNT_WIDTH'(job_parameters[RES_LSB +: FIELD_W]);
      end
      acc_q  <= acc_d;
      req_q  <= req_d;
      fcmp_q <= fcmp_d;
      cmp_q  <= cmp_d;
      prdy_q <= prdy_d;
      wrdy_q <= wrdy_d;
      cs_q   <= cs_d;
      busy_q <= busy_d;
    end
  end

  cnn_layer_accel_beat_cntr #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_pix (
    .clk_i(clk_if), .rst_ni(rst_n), .en_i(pix_en), .clr_i(cnt_clr),
    .target_i(pix_tgt_q), .count_o(pix_cnt),
    .done_o(pix_done), .done_nxt_o(pix_done_nxt)
  );

  cnn_layer_accel_beat_cntr #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_wgt (
    .clk_i(clk_if), .rst_ni(rst_n), .en_i(wgt_en), .clr_i(cnt_clr),
    .target_i(wgt_tgt_q), .count_o(wgt_cnt),
    .done_o(wgt_done), .done_nxt_o(wgt_done_nxt)
  );

  cnn_layer_accel_beat_cntr #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_res (
    .clk_i(clk_if), .rst_ni(rst_n), .en_i(res_en), .clr_i(cnt_clr),
    .target_i(res_tgt_q), .count_o(res_cnt),
    .done_o(res_done), .done_nxt_o(res_done_nxt)
  );

  logic unused_bits;
  assign unused_bits = ^{job_parameters[C_PARAM_WIDTH-1:FIELD_END],
                         pix_cnt, wgt_cnt, res_cnt, res_done_nxt};

  assign job_accept         = acc_q;
  assign job_fetch_request  = req_q;
  assign job_fetch_complete = fcmp_q;
  assign job_complete       = cmp_q;
  assign pixel_ready        = prdy_q;
  assign weight_ready       = wrdy_q;
  assign core_start         = cs_q;
  assign busy               = busy_q;

endmodule
